// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them to consecutive imem addresses from 0 and stalls the core until done.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [ADDR_W:0]     r_words_target;
    logic [ADDR_W:0]     r_words_written;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_byte_ready;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
    logic                r_cpu_hold;

    logic                w_accept;
    logic [ADDR_W:0]     w_words_next;
    logic                w_abort;

    assign w_accept     = byte_valid & r_byte_ready;
    assign w_words_next = r_words_written + ONE_WORD;
    assign w_abort      = abort & (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_words_target  <= '0;
            r_words_written <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_checksum      <= '0;
            r_byte_ready    <= 1'b0;
            r_we            <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_cpu_hold      <= 1'b1;
        end else if (w_abort) begin
            // Partial word dropped; the core stays held since nothing valid was loaded.
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_words_target  <= word_count;
                        r_words_written <= '0;
                        r_addr          <= '0;
                        r_checksum      <= '0;
                        r_idx           <= '0;
                        r_cpu_hold      <= 1'b1;
                        r_busy          <= 1'b1;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_COLLECT;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        case (r_idx)
                            2'd0:    r_wdata[31:24] <= byte_data;
                            2'd1:    r_wdata[23:16] <= byte_data;
                            2'd2:    r_wdata[15:8]  <= byte_data;
                            default: r_wdata[7:0]   <= byte_data;
                        endcase
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_we         <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_we            <= 1'b0;
                    r_checksum      <= r_checksum + r_wdata;
                    r_words_written <= w_words_next;
                    r_idx           <= '0;
                    // Address stays on the last written word once the load completes.
                    if (w_words_next == r_words_target) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr       <= r_addr + ADDR_W'(1);
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Abort must suppress the write strobe in the very cycle it is raised.
    assign imem_we    = r_we & ~abort;
    assign byte_ready = r_byte_ready;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cpu_hold   = r_cpu_hold;
    assign checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and compared whenever the loader strobes imem_we.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              abort = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic [DATA_W-1:0] checksum;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_writes = 0;
    int unsigned n_dones  = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] exp_sum = '0;
    logic [ADDR_W+DATA_W-1:0] sb[$];

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            n_writes++;
            last_addr = imem_addr;
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = sb.pop_front();
                check("wr_addr", imem_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                check("wr_data", imem_wdata, e[DATA_W-1:0]);
            end
        end
        if (rst_n && done) n_dones++;
    end

    // Called at a negedge; returns at the negedge after the byte's handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_timeout", 1'b0, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        sb.push_back({a, w});
        exp_sum = exp_sum + w;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            if (gaps) @(negedge clk);
        end
    endtask

    task automatic do_start(input int unsigned wc);
        start      = 1'b1;
        word_count = (ADDR_W+1)'(wc);
        exp_sum    = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_csum"}, checksum, exp_sum);
        check({tag, "_sb_empty"}, sb.size(), 0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int unsigned w0, d0;
        logic [31:0] w;

        repeat (3) @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_csum", checksum, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word, back-to-back bytes
        do_start(1);
        check("t1_busy", busy, 1);
        expect_word(8'd0, 32'h12345678);
        send_word(32'h12345678, 1'b0);
        check("t1_we", imem_we, 1);
        @(negedge clk);
        check("t1_done_lat", done, 1);
        wait_done("t1");

        // 2: two words with gapped byte_valid
        w0 = n_writes;
        do_start(2);
        expect_word(8'd0, 32'hA1B2C3D4);
        expect_word(8'd1, 32'h0F1E2D3C);
        send_word(32'hA1B2C3D4, 1'b1);
        send_word(32'h0F1E2D3C, 1'b1);
        wait_done("t2");
        check("t2_nwrites", n_writes - w0, 2);

        // 3: fill the whole memory with a counting byte pattern
        w0 = n_writes;
        do_start(256);
        for (int k = 0; k < 256; k++) begin
            w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            expect_word(8'(k), w);
            send_word(w, 1'b0);
        end
        wait_done("t3");
        check("t3_nwrites", n_writes - w0, 256);
        check("t3_last_addr", last_addr, 255);

        // 4: abort partway through the second word, then reload
        w0 = n_writes;
        d0 = n_dones;
        do_start(2);
        expect_word(8'd0, 32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_hold", cpu_hold, 1);
        check("t4_nodone", n_dones - d0, 0);
        check("t4_nwrites", n_writes - w0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_idle_abort", busy, 0);
        do_start(1);
        expect_word(8'd0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D, 1'b0);
        wait_done("t4");

        // 5: zero-length load, then start pulsed while busy
        w0 = n_writes;
        do_start(0);
        check("t5_done", done, 1);
        check("t5_csum", checksum, 0);
        @(negedge clk);
        check("t5_nwrites", n_writes - w0, 0);
        check("t5_hold", cpu_hold, 0);
        do_start(1);
        expect_word(8'd0, 32'h55AA1234);
        send_byte(8'h55);
        send_byte(8'hAA);
        start      = 1'b1;
        word_count = 9'd5;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h12);
        send_byte(8'h34);
        wait_done("t5");
        check("t5_nwrites_busy", n_writes - w0, 1);

        // 6: reset asserted during the write cycle
        do_start(1);
        expect_word(8'd0, 32'h87654321);
        send_word(32'h87654321, 1'b0);
        check("t6_we_pre", imem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we", imem_we, 0);
        check("t6_busy", busy, 0);
        check("t6_hold", cpu_hold, 1);
        check("t6_csum", checksum, 0);
        check("t6_addr", imem_addr, 0);
        check("t6_wdata", imem_wdata, 0);
        check("t6_ready", byte_ready, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
